// File: rtl/fix_ari_pkg.sv
// Shared fixed-point arithmetic definitions: signed range limits and overflow
// classification used by the saturating adder/subtractor family.
package fix_ari_pkg;

    typedef enum logic [1:0] {
        SAT_NONE = 2'd0,
        SAT_POS  = 2'd1,
        SAT_NEG  = 2'd2
    } sat_e;

    function automatic logic [63:0] fix_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] fix_min(input int w);
        return ~fix_max(w);
    endfunction

    // A DATA+1-bit exact result overflows DATA bits exactly when its two MSBs differ.
    function automatic sat_e sat_kind(input logic msb, input logic nxt);
        if (!msb && nxt) return SAT_POS;
        if (msb && !nxt) return SAT_NEG;
        return SAT_NONE;
    endfunction

endpackage

// File: rtl/fix_ari_sub_pipe_if.sv
// Streaming bus of the pipelined saturating subtractor: input beat, result
// beat and saturation status.
interface fix_ari_sub_pipe_if #(
    parameter int DATA  = 16,
    parameter int CNT_W = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    mode;
    logic                    clr;
    logic signed [DATA-1:0]  data_in1;
    logic signed [DATA-1:0]  data_in2;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [DATA-1:0]  data_out;
    logic                    sat_pos;
    logic                    sat_neg;
    logic [CNT_W-1:0]        sat_cnt;

    modport master (
        output in_valid, mode, clr, data_in1, data_in2, out_ready,
        input  in_ready, out_valid, data_out, sat_pos, sat_neg, sat_cnt
    );

    modport slave (
        input  in_valid, mode, clr, data_in1, data_in2, out_ready,
        output in_ready, out_valid, data_out, sat_pos, sat_neg, sat_cnt
    );
endinterface

// File: rtl/fix_ari_sat.sv
// Combinational clamp of a signed DATA+1-bit value into the signed DATA-bit
// range, flagging which limit was hit.
module fix_ari_sat
    import fix_ari_pkg::*;
#(
    parameter int DATA = 16
) (
    input  logic signed [DATA:0]   value_i,
    output logic signed [DATA-1:0] data_o,
    output logic                   sat_pos_o,
    output logic                   sat_neg_o
);
    localparam logic [63:0] MAX64 = fix_max(DATA);
    localparam logic [63:0] MIN64 = fix_min(DATA);
    localparam logic signed [DATA-1:0] MAX_V = MAX64[DATA-1:0];
    localparam logic signed [DATA-1:0] MIN_V = MIN64[DATA-1:0];

    sat_e kind;

    always_comb begin
        kind      = sat_kind(value_i[DATA], value_i[DATA-1]);
        data_o    = value_i[DATA-1:0];
        sat_pos_o = 1'b0;
        sat_neg_o = 1'b0;
        case (kind)
            SAT_POS: begin
                data_o    = MAX_V;
                sat_pos_o = 1'b1;
            end
            SAT_NEG: begin
                data_o    = MIN_V;
                sat_neg_o = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/fix_ari_sub_pipe.sv
// Two-stage saturating subtractor (in1 - in2 or running acc - in2) with
// valid/ready on both sides and a sticky saturation event counter.
module fix_ari_sub_pipe
    import fix_ari_pkg::*;
#(
    parameter int DATA  = 16,
    parameter int CNT_W = 8
) (
    input logic              clk,
    input logic              rst,
    fix_ari_sub_pipe_if.slave bus
);
    logic                   s2_load;
    logic                   s1_adv;
    logic                   accept;
    logic                   emit;
    logic signed [DATA-1:0] minuend;
    logic signed [DATA:0]   diff_d;
    logic signed [DATA-1:0] acc_q, acc_d, acc_sat;
    logic [1:0]             acc_flags_unused;
    logic signed [DATA:0]   diff_p1_q;
    logic                   vld_p1_q;
    logic signed [DATA-1:0] sat_data;
    logic                   sat_pos_w, sat_neg_w;
    logic signed [DATA-1:0] data_p2_q;
    logic                   pos_p2_q, neg_p2_q, vld_p2_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    assign s2_load = !vld_p2_q || bus.out_ready;
    assign s1_adv  = s2_load || !vld_p1_q;
    assign accept  = bus.in_valid && s1_adv;
    assign emit    = vld_p2_q && bus.out_ready;

    // clr zeroes the running minuend for a same-cycle accumulate beat
    always_comb begin
        minuend = bus.data_in1;
        if (bus.mode) begin
            minuend = bus.clr ? '0 : acc_q;
        end
    end

    assign diff_d = {minuend[DATA-1], minuend} - {bus.data_in2[DATA-1], bus.data_in2};

    fix_ari_sat #(.DATA(DATA)) u_sat_acc (
        .value_i   (diff_d),
        .data_o    (acc_sat),
        .sat_pos_o (acc_flags_unused[1]),
        .sat_neg_o (acc_flags_unused[0])
    );

    always_comb begin
        acc_d = acc_q;
        if (accept && bus.mode) begin
            acc_d = acc_sat;
        end else if (bus.clr) begin
            acc_d = '0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (bus.clr) begin
            cnt_d = '0;
        end else if (emit && (pos_p2_q || neg_p2_q) && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    fix_ari_sat #(.DATA(DATA)) u_sat_p2 (
        .value_i   (diff_p1_q),
        .data_o    (sat_data),
        .sat_pos_o (sat_pos_w),
        .sat_neg_o (sat_neg_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            diff_p1_q <= '0;
            vld_p2_q  <= 1'b0;
            data_p2_q <= '0;
            pos_p2_q  <= 1'b0;
            neg_p2_q  <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else begin
            // S1: exact DATA+1-bit difference
            if (s1_adv) begin
                vld_p1_q <= accept;
            end
            if (accept) begin
                diff_p1_q <= diff_d;
            end
            // S2: clamped result, held while downstream stalls
            if (s2_load) begin
                vld_p2_q <= vld_p1_q;
                if (vld_p1_q) begin
                    data_p2_q <= sat_data;
                    pos_p2_q  <= sat_pos_w;
                    neg_p2_q  <= sat_neg_w;
                end
            end
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = vld_p2_q;
    assign bus.data_out  = data_p2_q;
    assign bus.sat_pos   = pos_p2_q;
    assign bus.sat_neg   = neg_p2_q;
    assign bus.sat_cnt   = cnt_q;
endmodule

// File: tb/tb_fix_ari_sub_pipe.sv
// Randomised bench for fix_ari_sub_pipe against a queue-based transaction model.
module tb_fix_ari_sub_pipe;
    localparam int DATA  = 16;
    localparam int CNT_W = 8;
    localparam int VMAX  = 32767;
    localparam int VMIN  = -32768;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fix_ari_sub_pipe_if #(.DATA(DATA), .CNT_W(CNT_W)) bus ();

    fix_ari_sub_pipe #(.DATA(DATA), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int d;
        bit p;
        bit n;
        int age;
    } beat_t;

    beat_t pipe_q[$];
    int    m_acc = 0;
    int    m_cnt = 0;
    int    n_chk = 0;
    int    n_err = 0;
    bit    acc_flag;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sx(input int x);
        if ((x & 32'h8000) != 0) return x | 32'hFFFF0000;
        return x & 32'h0000FFFF;
    endfunction

    function automatic int clamp(input int v);
        if (v > VMAX) return VMAX;
        if (v < VMIN) return VMIN;
        return v;
    endfunction

    // One clock cycle, entered and left at the falling edge.
    task automatic cycle(input bit v, input bit m, input bit c, input int a, input int b,
                         input bit ordy, output bit acc_o);
        bit    exp_ovld, exp_rdy, accept, emit, flagged;
        int    mn, r;
        beat_t e;
        bus.in_valid  = v;
        bus.mode      = m;
        bus.clr       = c;
        bus.data_in1  = a[15:0];
        bus.data_in2  = b[15:0];
        bus.out_ready = ordy;
        #1;
        exp_ovld = (pipe_q.size() > 0) && (pipe_q[0].age >= 2);
        exp_rdy  = !((pipe_q.size() >= 2) && !ordy);
        check_eq("out_valid", 32'(bus.out_valid), 32'(exp_ovld));
        check_eq("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        check_eq("sat_cnt", 32'(bus.sat_cnt), 32'(m_cnt));
        if (exp_ovld) begin
            check_eq("data_out", {16'h0, bus.data_out}, 32'(pipe_q[0].d) & 32'h0000FFFF);
            check_eq("sat_pos", 32'(bus.sat_pos), 32'(pipe_q[0].p));
            check_eq("sat_neg", 32'(bus.sat_neg), 32'(pipe_q[0].n));
        end
        accept  = v && exp_rdy;
        emit    = exp_ovld && ordy;
        flagged = 1'b0;
        if (emit) begin
            flagged = pipe_q[0].p || pipe_q[0].n;
            void'(pipe_q.pop_front());
        end
        if (c) m_cnt = 0;
        else if (emit && flagged && m_cnt < 255) m_cnt++;
        if (accept) begin
            mn    = m ? (c ? 0 : m_acc) : sx(a);
            r     = mn - sx(b);
            e.d   = clamp(r);
            e.p   = (r > VMAX);
            e.n   = (r < VMIN);
            e.age = 0;
            pipe_q.push_back(e);
        end
        if (accept && m) m_acc = e.d;
        else if (c) m_acc = 0;
        acc_o = accept;
        @(posedge clk);
        foreach (pipe_q[i]) pipe_q[i].age++;
        @(negedge clk);
    endtask

    task automatic idle(input bit ordy);
        bit dummy;
        cycle(1'b0, 1'b0, 1'b0, 0, 0, ordy, dummy);
    endtask

    function automatic int pick_val();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF;
            1: return 32'h8000;
            2: return 32'hFFFF;
            3: return 32'h0001;
            default: return int'($urandom_range(0, 65535));
        endcase
    endfunction

    initial begin
        int sent, a, b;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.mode      = 1'b0;
        bus.clr       = 1'b0;
        bus.data_in1  = '0;
        bus.data_in2  = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_data_out", {16'h0, bus.data_out}, 32'd0);
        check_eq("rst_flags", {30'd0, bus.sat_pos, bus.sat_neg}, 32'd0);
        check_eq("rst_sat_cnt", 32'(bus.sat_cnt), 32'd0);
        check_eq("rst_acc", {16'h0, dut.acc_q}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // basic difference, latency 2
        cycle(1'b1, 1'b0, 1'b0, 100, 30, 1'b1, acc_flag);
        idle(1'b0);
        check_eq("basic_valid", 32'(bus.out_valid), 32'd1);
        check_eq("basic_dout", {16'h0, bus.data_out}, 32'd70);
        check_eq("basic_flags", {30'd0, bus.sat_pos, bus.sat_neg}, 32'd0);
        idle(1'b1);
        idle(1'b1);

        // saturation in difference mode
        cycle(1'b1, 1'b0, 1'b0, 32'h7FFF, 32'hFFFF, 1'b1, acc_flag);
        cycle(1'b1, 1'b0, 1'b0, 32'h8000, 32'h0001, 1'b1, acc_flag);
        idle(1'b0);
        check_eq("satpos_dout", {16'h0, bus.data_out}, 32'h7FFF);
        check_eq("satpos_flag", 32'(bus.sat_pos), 32'd1);
        repeat (3) idle(1'b1);
        check_eq("sat_cnt_two", 32'(bus.sat_cnt), 32'd2);

        // running decrement from a cleared accumulator
        cycle(1'b0, 1'b1, 1'b1, 0, 0, 1'b1, acc_flag);
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 0, 32'h4000, 1'b1, acc_flag);
        repeat (3) idle(1'b1);
        check_eq("acc_after_3", {16'h0, dut.acc_q}, 32'h8000);
        check_eq("acc_sat_cnt", 32'(bus.sat_cnt), 32'd1);

        // back-pressure: 8 beats with random out_ready
        sent = 0;
        a = int'($urandom_range(0, 65535));
        b = pick_val();
        for (int i = 0; i < 300 && sent < 8; i++) begin
            cycle(1'b1, 1'b0, 1'b0, a, b, i < 3 ? 1'b0 : 1'($urandom_range(0, 1)), acc_flag);
            if (acc_flag) begin
                sent++;
                a = int'($urandom_range(0, 65535));
                b = pick_val();
            end
        end
        check_eq("bp_sent", 32'(sent), 32'd8);
        repeat (4) idle(1'b1);

        // clr colliding with an accumulate beat
        cycle(1'b1, 1'b1, 1'b1, 0, 5, 1'b1, acc_flag);
        idle(1'b0);
        check_eq("clr_beat_dout", {16'h0, bus.data_out}, 32'hFFFB);
        idle(1'b1);
        check_eq("clr_beat_acc", {16'h0, dut.acc_q}, 32'hFFFB);

        // clr colliding with a saturated emit
        cycle(1'b1, 1'b0, 1'b0, 32'h7FFF, 32'h8001, 1'b0, acc_flag);
        idle(1'b0);
        idle(1'b0);
        cycle(1'b0, 1'b0, 1'b1, 0, 0, 1'b1, acc_flag);
        idle(1'b1);
        check_eq("clr_emit_cnt", 32'(bus.sat_cnt), 32'd0);

        // random mix
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 15) == 0), pick_val(), pick_val(),
                  1'($urandom_range(0, 3) != 0), acc_flag);
        end
        repeat (4) idle(1'b1);

        // asynchronous reset with both stages full
        cycle(1'b1, 1'b0, 1'b0, 1, 2, 1'b0, acc_flag);
        cycle(1'b1, 1'b1, 1'b0, 3, 32'h7000, 1'b0, acc_flag);
        cycle(1'b1, 1'b0, 1'b0, 5, 6, 1'b0, acc_flag);
        bus.in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check_eq("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("arst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("arst_data_out", {16'h0, bus.data_out}, 32'd0);
        check_eq("arst_flags", {30'd0, bus.sat_pos, bus.sat_neg}, 32'd0);
        check_eq("arst_sat_cnt", 32'(bus.sat_cnt), 32'd0);
        check_eq("arst_acc", {16'h0, dut.acc_q}, 32'd0);
        pipe_q.delete();
        m_acc = 0;
        m_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 9, 4, 1'b1, acc_flag);
        idle(1'b0);
        check_eq("post_rst_valid", 32'(bus.out_valid), 32'd1);
        check_eq("post_rst_dout", {16'h0, bus.data_out}, 32'd5);
        repeat (2) idle(1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
